// File: rtl/bcd_digit_entry.sv
// Decimal digit entry: shifts up to three digits into a right-aligned BCD register and
// hands the committed number downstream through a valid/ready handshake.
module bcd_digit_entry #(
  parameter int unsigned IDLE_TIMEOUT = 1000,
  parameter int unsigned TO_W         = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit_in,
  input  logic       digit_valid,
  output logic       digit_ready,
  input  logic       enter,
  input  logic       clear,
  output logic [3:0] huns,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       bcd_valid,
  input  logic       bcd_ready,
  output logic [1:0] count,
  output logic       err
);

  typedef enum logic [1:0] {StIdle, StEntry, StHold} state_e;

  // Timer value on the cycle whose edge completes the idle period.
  localparam logic [TO_W-1:0] TimeoutLast = TO_W'(IDLE_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [3:0]      huns_q, huns_d, tens_q, tens_d, units_q, units_d;
  logic [1:0]      count_q, count_d;
  logic [TO_W-1:0] timer_q, timer_d;
  logic            err_q, err_d;

  logic accept, store, reject, timeout_hit;

  assign digit_ready = ~rst & (state_q != StHold);
  assign accept      = digit_valid & digit_ready;
  // Only legal digits with room left are stored; every other accepted code is rejected.
  assign store       = accept & (digit_in <= 4'd9) & (count_q != 2'd3);
  assign reject      = accept & ~store;
  assign timeout_hit = (IDLE_TIMEOUT != 0) && (timer_q == TimeoutLast) && !store;

  // Next-state: entry shifting, commit, handshake release and clear override.
  always_comb begin
    state_d = state_q;
    huns_d  = huns_q;
    tens_d  = tens_q;
    units_d = units_q;
    count_d = count_q;
    timer_d = timer_q;
    err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        timer_d = '0;
        err_d   = reject;
        if (store) begin
          huns_d  = tens_q;
          tens_d  = units_q;
          units_d = digit_in;
          count_d = count_q + 2'd1;
          state_d = enter ? StHold : StEntry;
        end
      end
      StEntry: begin
        err_d = reject;
        if (store) begin
          huns_d  = tens_q;
          tens_d  = units_q;
          units_d = digit_in;
          count_d = count_q + 2'd1;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TO_W'(1);
        end
        if (enter || timeout_hit) begin
          state_d = StHold;
          timer_d = '0;
        end
      end
      StHold: begin
        timer_d = '0;
        if (bcd_ready) begin
          state_d = StIdle;
          huns_d  = '0;
          tens_d  = '0;
          units_d = '0;
          count_d = '0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Clear wins over everything except reset; a digit offered with it is silently dropped.
    if (clear) begin
      state_d = StIdle;
      huns_d  = '0;
      tens_d  = '0;
      units_d = '0;
      count_d = '0;
      timer_d = '0;
      err_d   = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      huns_q  <= '0;
      tens_q  <= '0;
      units_q <= '0;
      count_q <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      huns_q  <= huns_d;
      tens_q  <= tens_d;
      units_q <= units_d;
      count_q <= count_d;
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  assign huns      = huns_q;
  assign tens      = tens_q;
  assign units     = units_q;
  assign count     = count_q;
  assign bcd_valid = (state_q == StHold);
  assign err       = err_q;

endmodule

// File: tb/tb_bcd_digit_entry.sv
// Self-checking bench for bcd_digit_entry: directed scenarios plus randomized traffic, all
// compared against an arithmetic reference model of the entered number.
module tb_bcd_digit_entry;

  localparam int unsigned TO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] digit_in;
  logic       digit_valid;
  logic       digit_ready;
  logic       enter;
  logic       clear;
  logic [3:0] huns, tens, units;
  logic       bcd_valid;
  logic       bcd_ready;
  logic [1:0] count;
  logic       err;

  int checks = 0;
  int errors = 0;

  // Reference model: the entered number as an integer, digit count, held flag, idle cycles.
  int m_val  = 0;
  int m_n    = 0;
  int m_idle = 0;
  bit m_held = 0;
  bit m_err  = 0;

  bcd_digit_entry #(
    .IDLE_TIMEOUT(TO),
    .TO_W        (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .digit_in   (digit_in),
    .digit_valid(digit_valid),
    .digit_ready(digit_ready),
    .enter      (enter),
    .clear      (clear),
    .huns       (huns),
    .tens       (tens),
    .units      (units),
    .bcd_valid  (bcd_valid),
    .bcd_ready  (bcd_ready),
    .count      (count),
    .err        (err)
  );

  always #5 clk = ~clk;

  function automatic void check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  function automatic void model_step();
    bit acc, ok;
    int n0;
    acc    = digit_valid && !rst && !m_held;
    ok     = acc && (digit_in <= 4'd9) && (m_n < 3);
    n0     = m_n;
    m_err  = 0;
    if (rst || clear) begin
      m_val = 0; m_n = 0; m_held = 0; m_idle = 0;
    end else if (m_held) begin
      if (bcd_ready) begin
        m_val = 0; m_n = 0; m_held = 0;
      end
    end else begin
      m_err = acc && !ok;
      if (ok) begin
        m_val  = m_val * 10 + int'(digit_in);
        m_n    = m_n + 1;
        m_idle = 0;
      end else if (n0 > 0) begin
        m_idle = m_idle + 1;
      end
      if ((n0 > 0 || ok) && (enter || m_idle == int'(TO))) begin
        m_held = 1;
        m_idle = 0;
      end
    end
  endfunction

  function automatic void check_all();
    check("huns", huns, m_val / 100);
    check("tens", tens, (m_val / 10) % 10);
    check("units", units, m_val % 10);
    check("count", count, m_n);
    check("bcd_valid", bcd_valid, m_held);
    check("err", err, m_err);
  endfunction

  task automatic step(input bit r, input bit dv, input logic [3:0] d, input bit en,
                      input bit cl, input bit br);
    rst = r; digit_valid = dv; digit_in = d; enter = en; clear = cl; bcd_ready = br;
    #1;
    check("digit_ready", digit_ready, !r && !m_held);
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic dig(input logic [3:0] d);
    step(0, 1, d, 0, 0, 0);
  endtask

  task automatic idle_step(input bit br);
    step(0, 0, 4'd0, 0, 0, br);
  endtask

  task automatic expect_num(input string tag, input int h, input int t, input int u);
    check({tag, "_huns"}, huns, h);
    check({tag, "_tens"}, tens, t);
    check({tag, "_units"}, units, u);
  endtask

  initial begin
    bit r, dv, en, cl, br;
    logic [3:0] d;

    // Reset state
    step(1, 0, 4'd0, 0, 0, 0);
    step(1, 1, 4'd3, 1, 0, 1);
    expect_num("reset", 0, 0, 0);
    check("reset_count", count, 0);

    // 4,5,6 then enter with consumer ready: valid for exactly one cycle
    dig(4'd4); dig(4'd5); dig(4'd6);
    step(0, 0, 4'd0, 1, 0, 1);
    expect_num("t1", 4, 5, 6);
    check("t1_valid", bcd_valid, 1);
    idle_step(1);
    check("t1_valid_drop", bcd_valid, 0);
    check("t1_count", count, 0);

    // Two digits, then overflow on the fourth digit
    dig(4'd7); dig(4'd2);
    step(0, 0, 4'd0, 1, 0, 0);
    expect_num("t2a", 0, 7, 2);
    check("t2a_count", count, 2);
    idle_step(1);
    dig(4'd1); dig(4'd2); dig(4'd3);
    check("t2_no_err", err, 0);
    dig(4'd4);
    check("t2_overflow_err", err, 1);
    step(0, 0, 4'd0, 1, 0, 0);
    expect_num("t2b", 1, 2, 3);
    idle_step(1);

    // Illegal code in ENTRY, two consecutive rejects, then a legal digit
    dig(4'd7);
    dig(4'hA);
    check("t3_err", err, 1);
    check("t3_count", count, 1);
    dig(4'hF);
    check("t3_err2", err, 1);
    dig(4'd9);
    check("t3_err_clear", err, 0);
    expect_num("t3", 0, 7, 9);
    step(0, 0, 4'd0, 1, 0, 0);
    idle_step(1);

    // HOLD stalls with consumer not ready while digits keep arriving
    dig(4'd8);
    step(0, 0, 4'd0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 4'd1, 0, 0, 0);
    expect_num("t4", 0, 0, 8);
    check("t4_valid", bcd_valid, 1);
    idle_step(1);
    check("t4_release", bcd_valid, 0);

    // Idle timeout commits 8 cycles after the last accepted digit; clear leaves HOLD
    dig(4'd3);
    for (int i = 0; i < 7; i++) idle_step(0);
    check("t5_not_yet", bcd_valid, 0);
    idle_step(0);
    check("t5_timeout", bcd_valid, 1);
    expect_num("t5", 0, 0, 3);
    step(0, 1, 4'd2, 0, 1, 0);
    check("t5_clear", bcd_valid, 0);
    expect_num("t5c", 0, 0, 0);

    // Reset mid-entry and mid-HOLD
    dig(4'd1); dig(4'd2);
    step(1, 1, 4'd5, 0, 0, 0);
    expect_num("t6a", 0, 0, 0);
    dig(4'd4);
    step(0, 0, 4'd0, 1, 0, 0);
    step(1, 0, 4'd0, 0, 0, 0);
    check("t6_rst_hold", bcd_valid, 0);
    step(0, 0, 4'd0, 1, 0, 0);
    check("t6_enter_idle", bcd_valid, 0);
    step(0, 1, 4'd5, 1, 0, 0);
    check("t6_first_commit", bcd_valid, 1);
    expect_num("t6b", 0, 0, 5);
    idle_step(1);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 63) == 0);
      cl = ($urandom_range(0, 31) == 0);
      en = ($urandom_range(0, 7) == 0);
      dv = ($urandom_range(0, 1) == 1);
      br = ($urandom_range(0, 2) == 0);
      d  = 4'($urandom_range(0, 11));
      // Keep enter away from digits that would be rejected in the same cycle.
      if (en && (d > 4'd9 || m_n == 3)) dv = 0;
      step(r, dv, d, en, cl, br);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
